// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg
//   Shared definitions for the counter monitor: default widths and the
//   checker state encoding. Imported by counter_monitor and sat_counter.
package counter_monitor_pkg;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_STAT_W = 8;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,  // no reference held, nothing checked
    TRACK  = 2'd1,  // reference held, no mismatch seen yet
    FAULT  = 2'd2   // reference held, at least one mismatch seen
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   clr   : synchronous clear, wins over inc
//   count : current count
module sat_counter
  import counter_monitor_pkg::*;
#(
  parameter int W = DEF_STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// counter_monitor
//   Watches an external up-counter and checks it against the reference
//   cnt(n+1) = (cnt(n) + en(n)) mod 2^CNT_W, keeping error and wrap stats.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset of the whole block
//   dut_rst  : observed counter is being held in reset
//   en       : enable seen by the observed counter this cycle
//   cnt      : observed counter value
//   clear    : one-cycle request to drop lock and zero all statistics
//   locked   : reference held and checking active (TRACK or FAULT)
//   err      : sticky, set on first mismatch
//   err_cnt  : mismatching cycles, saturating
//   wrap_cnt : correct max->0 wraps, modulo 2^STAT_W
//   exp_val  : expected value at the first mismatch
//   got_val  : observed value at the first mismatch
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              clear,
  output logic              locked,
  output logic              err,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0]  exp_val,
  output logic [CNT_W-1:0]  got_val
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   prev_cnt;
  logic               prev_en;
  logic [CNT_W-1:0]   exp_cnt;
  logic               checking;
  logic               mismatch;
  logic               wrap_hit;

  // Value the observed counter should show now, given last cycle's sample.
  assign exp_cnt  = prev_cnt + CNT_W'(prev_en);

  // A cycle is only judged while a reference is held; a counter reset or a
  // clear request in the same cycle suppresses both error and wrap counting.
  assign checking = (state != UNSYNC) && !dut_rst && !clear;
  assign mismatch = checking && (cnt != exp_cnt);
  assign wrap_hit = checking && (prev_cnt == '1) && prev_en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UNSYNC;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state is assigned a default before any branch so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    next_state = state;
    if (clear || dut_rst) begin
      next_state = UNSYNC;
    end else begin
      unique case (state)
        UNSYNC:  next_state = TRACK;  // this cycle's sample becomes the reference
        TRACK:   if (mismatch) next_state = FAULT;
        FAULT:   next_state = FAULT;
        default: next_state = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked   <= 1'b0;
      prev_cnt <= '0;
      prev_en  <= 1'b0;
      err      <= 1'b0;
      wrap_cnt <= '0;
      exp_val  <= '0;
      got_val  <= '0;
    end else begin
      // locked is driven from next_state so it is a flop aligned with state.
      locked   <= (next_state != UNSYNC);
      prev_cnt <= cnt;
      prev_en  <= en;
      if (clear) begin
        err      <= 1'b0;
        wrap_cnt <= '0;
        exp_val  <= '0;
        got_val  <= '0;
      end else begin
        if (mismatch) begin
          err <= 1'b1;
          // Only the first mismatch since the last clear is recorded.
          if (!err) begin
            exp_val <= exp_cnt;
            got_val <= cnt;
          end
        end
        if (wrap_hit) begin
          wrap_cnt <= wrap_cnt + STAT_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .W (STAT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch),
    .clr   (clear),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor
//   Directed stimulus for counter_monitor. After each step the driver may
//   push a hand-computed expected output record tagged with the clock edge
//   it belongs to; an independent monitor pops records on the following
//   falling edge and compares every output field.
module tb_counter_monitor;

  localparam int CNT_W  = 4;
  localparam int STAT_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              dut_rst;
  logic              en;
  logic [CNT_W-1:0]  cnt;
  logic              clear;
  logic              locked;
  logic              err;
  logic [STAT_W-1:0] err_cnt;
  logic [STAT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0]  exp_val;
  logic [CNT_W-1:0]  got_val;

  typedef struct {
    int                tag;
    string             name;
    logic              locked;
    logic              err;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0]  exp_val;
    logic [CNT_W-1:0]  got_val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   edges  = 0;
  int   checks = 0;
  int   errors = 0;

  counter_monitor #(
    .CNT_W  (CNT_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dut_rst  (dut_rst),
    .en       (en),
    .cnt      (cnt),
    .clear    (clear),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt),
    .exp_val  (exp_val),
    .got_val  (got_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, got, want);
    end
  endtask

  // Apply one cycle of inputs; returns just after the edge that sampled them.
  task automatic step(input logic r, input logic e, input logic [CNT_W-1:0] c,
                      input logic cl);
    dut_rst = r;
    en      = e;
    cnt     = c;
    clear   = cl;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs right after the edge just taken.
  task automatic exp_push(input string name, input logic lk, input logic er,
                          input int ec, input int wc, input int ev, input int gv);
    exp_t x;
    x.tag      = edges;
    x.name     = name;
    x.locked   = lk;
    x.err      = er;
    x.err_cnt  = STAT_W'(ec);
    x.wrap_cnt = STAT_W'(wc);
    x.exp_val  = CNT_W'(ev);
    x.got_val  = CNT_W'(gv);
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].tag <= edges) begin
      cur = sb.pop_front();
      if (cur.tag != edges) begin
        check({cur.name, ".missed"}, 32'(edges), 32'(cur.tag));
      end else begin
        check({cur.name, ".locked"},   32'(locked),   32'(cur.locked));
        check({cur.name, ".err"},      32'(err),      32'(cur.err));
        check({cur.name, ".err_cnt"},  32'(err_cnt),  32'(cur.err_cnt));
        check({cur.name, ".wrap_cnt"}, 32'(wrap_cnt), 32'(cur.wrap_cnt));
        check({cur.name, ".exp_val"},  32'(exp_val),  32'(cur.exp_val));
        check({cur.name, ".got_val"},  32'(got_val),  32'(cur.got_val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1;
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'd7, 1'b1);
    exp_push("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Correct counting with en high; lock after the first sample, one wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, CNT_W'(i), 1'b0);
      if (i == 0)  exp_push("count_lock",    1, 0, 0, 0, 0, 0);
      if (i == 15) exp_push("count_pre_wrap", 1, 0, 0, 0, 0, 0);
      if (i == 16) exp_push("count_wrap",    1, 0, 0, 1, 0, 0);
    end
    exp_push("count_end", 1, 0, 0, 1, 0, 0);

    // Skip from 5 to 7 with en high.
    step(1'b0, 1'b1, 4'd4, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    exp_push("skip_err",   1, 1, 1, 1, 6, 7);
    step(1'b0, 1'b1, 4'd8, 1'b0);
    exp_push("skip_after", 1, 1, 1, 1, 6, 7);
    step(1'b0, 1'b1, 4'd9, 1'b1);
    exp_push("skip_clear", 0, 0, 0, 0, 0, 0);

    // Hold at 9 with en low, then an illegal change to 10.
    step(1'b0, 1'b0, 4'd9, 1'b0);
    exp_push("hold_lock", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd9, 1'b0);
    exp_push("hold_ok",   1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 4'd10, 1'b0);
    exp_push("hold_move", 1, 1, 1, 0, 9, 10);
    step(1'b0, 1'b1, 4'd0, 1'b1);
    exp_push("hold_clear", 0, 0, 0, 0, 0, 0);

    // Observed counter reset mid-count at 12, then restart from 0.
    for (int i = 8; i <= 12; i++) step(1'b0, 1'b1, CNT_W'(i), 1'b0);
    exp_push("rst_before", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 4'd0, 1'b0);
      exp_push("rst_pulse", 0, 0, 0, 0, 0, 0);
    end
    step(1'b0, 1'b1, 4'd0, 1'b0);
    exp_push("rst_relock", 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    exp_push("rst_track",  1, 0, 0, 0, 0, 0);

    // 300 consecutive mismatches: cnt toggles 6/5 while en is low.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0) ? 4'd6 : 4'd5, 1'b0);
      if (i == 99)  exp_push("sat_100", 1, 1, 100, 0, 3, 6);
      if (i == 254) exp_push("sat_255", 1, 1, 255, 0, 3, 6);
    end
    exp_push("sat_stay", 1, 1, 255, 0, 3, 6);
    step(1'b0, 1'b0, 4'd5, 1'b1);
    exp_push("sat_clear",  0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    exp_push("sat_relock", 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    exp_push("sat_track",  1, 0, 0, 0, 0, 0);

    // clear on the same cycle as a mismatch (expected 2, got 5).
    step(1'b0, 1'b1, 4'd5, 1'b1);
    exp_push("clr_mis",   0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 4'd6, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    exp_push("clr_after", 1, 0, 0, 0, 0, 0);

    // Statistics survive dut_rst; dut_rst together with clear acts as clear.
    step(1'b0, 1'b1, 4'd8, 1'b0);
    step(1'b0, 1'b1, 4'd13, 1'b0);
    exp_push("ret_err",   1, 1, 1, 0, 9, 13);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    exp_push("ret_keep",  0, 1, 1, 0, 9, 13);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    exp_push("ret_clear", 0, 0, 0, 0, 0, 0);

    // Wrap 15->0, then block reset overriding clear and dut_rst.
    step(1'b0, 1'b1, 4'd14, 1'b0);
    step(1'b0, 1'b1, 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    exp_push("wrap2", 1, 0, 0, 1, 0, 0);
    reset = 1'b1;
    step(1'b1, 1'b1, 4'd9, 1'b1);
    exp_push("reset_again", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter CNT_W, default 4, width of the monitored count.
REQ-002 Parameter STAT_W, default 8, width of the error and wrap statistics counters.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high block reset.
REQ-006 dut_rst  input  1  high while the observed counter is held in reset (its reset_n low, inverted externally).
REQ-007 en  input  1  the enable driven to the observed counter, sampled the same edge the counter samples it.
REQ-008 cnt  input  CNT_W  the observed counter output.
REQ-009 clear  input  1  single-cycle request to clear the error state and statistics.
REQ-010 locked  output  1  high when a reference value is held and checking is active.
REQ-011 err  output  1  sticky flag; high from the first mismatch until clear or reset.
REQ-012 err_cnt  output  STAT_W  number of mismatching cycles; saturates at all-ones.
REQ-013 wrap_cnt  output  STAT_W  number of correct wraps from 2^CNT_W-1 to 0; wraps modulo 2^STAT_W.
REQ-014 exp_val  output  CNT_W  expected count at the first mismatch.
REQ-015 got_val  output  CNT_W  observed count at the first mismatch.

Function
REQ-016 The observed counter's reference behaviour is cnt(n+1) = (cnt(n) + en(n)) mod 2^CNT_W, and the block SHALL check against it.
REQ-017 The block SHALL register prev_cnt and prev_en every cycle and compute exp = (prev_cnt + prev_en) mod 2^CNT_W.
REQ-018 The FSM SHALL have states UNSYNC, TRACK and FAULT.
REQ-019 UNSYNC: no checking; on the first cycle with dut_rst low, capture cnt and en, then go to TRACK on the next cycle.
REQ-020 TRACK: if cnt != exp, go to FAULT; set err; increment err_cnt; load exp_val and got_val.
REQ-021 FAULT: keep checking every cycle against exp from the observed values, so each mismatching cycle increments err_cnt once; exp_val and got_val keep the first mismatch.
REQ-022 wrap_cnt SHALL increment in TRACK or FAULT when prev_cnt == 2^CNT_W-1, prev_en == 1 and cnt == 0.
REQ-023 A hold with en low (cnt unchanged) SHALL be a match; a change while en was low SHALL be a mismatch.
REQ-024 dut_rst high in any state SHALL force UNSYNC the next cycle, with no mismatch counted that cycle; err, err_cnt, wrap_cnt, exp_val and got_val are retained.
REQ-025 clear SHALL force UNSYNC and zero err, err_cnt, wrap_cnt, exp_val and got_val the next cycle.
REQ-026 clear takes priority over a mismatch or wrap in the same cycle.
REQ-027 dut_rst and clear together SHALL behave as clear.
REQ-028 locked SHALL be high exactly in TRACK and FAULT.
REQ-029 All outputs SHALL be registered, with one cycle of latency from the offending cnt sample to err, err_cnt and got_val.
REQ-030 err_cnt at all-ones SHALL stay at all-ones on further mismatches.

Reset
REQ-031 reset SHALL place the FSM in UNSYNC and set locked, err, err_cnt, wrap_cnt, exp_val, got_val, prev_cnt and prev_en to 0.
REQ-032 reset SHALL override clear, dut_rst and all checking in the same cycle.

Structure
REQ-033 Package counter_monitor_pkg SHALL hold the state enum (UNSYNC, TRACK, FAULT) and the default width constants.
REQ-034 Sub-module sat_counter (width parameter, inc, clr, saturating output) SHALL implement err_cnt.
REQ-035 The total RTL size SHALL be 120-400 lines.

Verification
REQ-036 Reset; dut_rst low; en=1 for 20 cycles with a correct counter -> locked=1 from cycle 2, err=0, wrap_cnt=1 after the 15->0 step.
REQ-037 Correct counter; force cnt 5->7 with en=1 -> err=1 next cycle, err_cnt=1, exp_val=6, got_val=7, state FAULT.
REQ-038 en=0, cnt holds 9 for 10 cycles, then cnt 9->10 with en=0 -> no error during the hold; at the change err=1, exp_val=9, got_val=10.
REQ-039 dut_rst pulsed for 4 cycles mid-count at cnt=12, counter restarts at 0 -> locked=0 during the pulse, no err, re-lock after release.
REQ-040 300 consecutive injected mismatches with STAT_W=8 -> err_cnt=255 and it stays there; clear -> all statistics 0, locked=0, then re-lock.
REQ-041 clear asserted on the same cycle as a mismatch -> err=0 and err_cnt=0 afterwards.
